uart_tx_feeder: RTL and testbench

- Byte FIFO plus sequencer that sits directly upstream of the 9600-baud serial transmitter. It lets producers push bytes in bursts.
- Toward the transmitter it issues one start pulse per byte and holds the data bus stable for the whole frame. It then waits for the transmitter's one-cycle done pulse before issuing the next byte.
- Includes a done-timeout so a stalled transmitter cannot wedge the feeder.

---
 rtl/uart_tx_feeder_if.sv | 22 ++
 rtl/uart_tx_feeder.sv | 66 ++++++
 tb/tb_uart_tx_feeder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: producer push port, status flags and transmitter handshake of the feeder
interface uart_tx_feeder_if #(parameter int DEPTH_LOG2 = 4);
  logic wr_en;
  logic [7:0] wr_data;
  logic full;
  logic empty;
  logic [DEPTH_LOG2:0] count;
  logic overflow;
  logic tx_err;
  logic busy;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_done;
  modport master(
    output wr_en, wr_data, tx_done,
    input full, empty, count, overflow, tx_err, busy, tx_start, tx_data
  );
  modport slave(
    input wr_en, wr_data, tx_done,
    output full, empty, count, overflow, tx_err, busy, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus start/done sequencer with done timeout for a serial transmitter
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT_W = 17
) (
  input logic clk,
  input logic rst,
  uart_tx_feeder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic [7:0] tx_data_q;
  logic overflow_q, tx_err_q;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic push, pop, timed_out;
  assign push = bus.wr_en && !bus.full;
  assign pop = state_q == LOAD;
  assign timed_out = state_q == WAIT && !bus.tx_done && &tmo_q;
  assign bus.full = count_q[DEPTH_LOG2];
  assign bus.empty = count_q == '0;
  assign bus.count = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_err = tx_err_q;
  assign bus.busy = state_q != IDLE;
  assign bus.tx_start = state_q == START;
  assign bus.tx_data = tx_data_q;
  always_comb begin
    state_d = state_q == IDLE  ? (bus.empty ? IDLE : LOAD) :
              state_q == LOAD  ? START :
              state_q == START ? WAIT :
              (bus.tx_done || &tmo_q) ? IDLE : WAIT;
    tmo_d = state_q == START ? '0 :
            (state_q == WAIT && !bus.tx_done && !(&tmo_q)) ? tmo_q + TIMEOUT_W'(1) : tmo_q;
    count_d = (push && !pop) ? count_q + (DEPTH_LOG2+1)'(1) :
              (!push && pop) ? count_q - (DEPTH_LOG2+1)'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      tx_data_q <= 8'h00;
      overflow_q <= 1'b0;
      tx_err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmo_q <= tmo_d;
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        tx_data_q <= mem[rd_ptr_q];
      end
      if (bus.wr_en && bus.full) overflow_q <= 1'b1;
      if (timed_out) tx_err_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= bus.wr_data;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized scenario bench for uart_tx_feeder against a queue-based transmitter model
module tb_uart_tx_feeder;
  localparam int TW = 8;
  localparam int TMO = 1 << TW;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc[$];
  logic [7:0] start_dat[$];
  int done_cyc[$];
  int stab_bad = 0;
  bit in_frame = 1'b0;
  logic [7:0] frame_dat = 8'h00;
  bit hold_done = 1'b0;
  int done_delay = 110;
  int done_at = -1;
  uart_tx_feeder_if #(.DEPTH_LOG2(4)) bus();
  uart_tx_feeder #(.DEPTH_LOG2(4), .TIMEOUT_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.tx_done = (cyc == done_at);
    if (bus.tx_done) begin
      done_cyc.push_back(cyc);
      in_frame = 1'b0;
    end
    if (bus.tx_start) begin
      start_cyc.push_back(cyc);
      start_dat.push_back(bus.tx_data);
      in_frame = 1'b1;
      frame_dat = bus.tx_data;
      if (!hold_done) done_at = cyc + done_delay;
    end else if (in_frame && bus.tx_data !== frame_dat) stab_bad++;
  endtask
  task automatic push(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic clear_logs();
    start_cyc.delete();
    start_dat.delete();
    done_cyc.delete();
    stab_bad = 0;
    in_frame = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy || !bus.empty) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.busy || !bus.empty) begin
      failures++;
      $display("FAIL idle_wait busy=%0b empty=%0b still after %0d cycles", bus.busy, bus.empty, budget);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hAA;
    tick();
    tick();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.tx_err !== 1'b0) begin failures++; $display("FAIL reset_tx_err got=%b exp=0", bus.tx_err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    repeat (3) tick();
    checks++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0 || start_cyc.size() != 0) begin
      failures++; $display("FAIL reset_no_push empty=%b busy=%b starts=%0d exp empty=1 busy=0 starts=0", bus.empty, bus.busy, start_cyc.size());
    end
  endtask
  task automatic test_single();
    int p;
    clear_logs();
    hold_done = 1'b0;
    done_delay = 110;
    p = cyc;
    push(8'h55);
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL single_empty_after_push got=%b exp=0", bus.empty); end
    wait_idle(400);
    checks++; if (start_cyc.size() != 1) begin failures++; $display("FAIL single_start_count got=%0d exp=1", start_cyc.size()); end
    if (start_cyc.size() >= 1) begin
      checks++; if (start_cyc[0] != p + 3) begin failures++; $display("FAIL single_start_latency got=%0d exp=%0d", start_cyc[0] - p, 3); end
      checks++; if (start_dat[0] !== 8'h55) begin failures++; $display("FAIL single_tx_data got=%h exp=55", start_dat[0]); end
    end
    if (done_cyc.size() >= 1) begin
      checks++; if (cyc != done_cyc[0] + 1) begin failures++; $display("FAIL single_busy_fall got=%0d exp=%0d", cyc, done_cyc[0] + 1); end
    end
    checks++; if (stab_bad != 0) begin failures++; $display("FAIL single_data_stable changes=%0d exp=0", stab_bad); end
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", bus.count); end
  endtask
  task automatic test_burst();
    logic [7:0] b [4] = '{8'h48, 8'h49, 8'h0D, 8'h0A};
    int p;
    clear_logs();
    done_delay = $urandom_range(120, 20);
    p = cyc;
    for (int i = 0; i < 4; i++) push(b[i]);
    wait_idle(2000);
    checks++; if (start_cyc.size() != 4) begin failures++; $display("FAIL burst_start_count got=%0d exp=4", start_cyc.size()); end
    for (int i = 0; i < 4 && i < start_cyc.size(); i++) begin
      checks++; if (start_dat[i] !== b[i]) begin failures++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, start_dat[i], b[i]); end
      if (i == 0) begin
        checks++; if (start_cyc[0] != p + 3) begin failures++; $display("FAIL burst_first_latency got=%0d exp=3", start_cyc[0] - p); end
      end else if (done_cyc.size() >= i) begin
        checks++; if (start_cyc[i] != done_cyc[i-1] + 3) begin failures++; $display("FAIL burst_gap[%0d] got=%0d exp=3", i, start_cyc[i] - done_cyc[i-1]); end
      end
    end
    checks++; if (stab_bad != 0) begin failures++; $display("FAIL burst_data_stable changes=%0d exp=0", stab_bad); end
  endtask
  task automatic test_full_overflow();
    int p;
    clear_logs();
    hold_done = 1'b1;
    p = cyc;
    for (int j = 0; j < 17; j++) push(8'(j));
    checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL full_before_drop count=%0d full=%b exp count=16 full=1", bus.count, bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL full_overflow_early got=%b exp=0", bus.overflow); end
    push(8'h11);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL full_overflow_set got=%b exp=1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL full_count_after_drop got=%0d exp=16", bus.count); end
    checks++; if (start_cyc.size() < 1 || start_cyc[0] != p + 3) begin failures++; $display("FAIL full_first_pop starts=%0d first_start_offset exp=3", start_cyc.size()); end
    hold_done = 1'b0;
    done_delay = $urandom_range(40, 5);
    done_at = cyc + 1;
    wait_idle(3000);
    checks++; if (start_cyc.size() != 17) begin failures++; $display("FAIL full_drain_count got=%0d exp=17", start_cyc.size()); end
    for (int i = 0; i < start_cyc.size() && i < 17; i++) begin
      checks++; if (start_dat[i] !== 8'(i)) begin failures++; $display("FAIL full_drain_data[%0d] got=%h exp=%h", i, start_dat[i], 8'(i)); end
    end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL full_overflow_sticky got=%b exp=1", bus.overflow); end
  endtask
  task automatic test_simul_push_pop();
    logic [7:0] a [5];
    int d;
    clear_logs();
    for (int i = 0; i < 4; i++) a[i] = 8'($urandom);
    a[4] = 8'h77;
    hold_done = 1'b1;
    for (int i = 0; i < 4; i++) push(a[i]);
    for (int n = 0; n < 10 && start_cyc.size() == 0; n++) tick();
    checks++; if (bus.count !== 5'd3) begin failures++; $display("FAIL simul_count_in_frame got=%0d exp=3", bus.count); end
    d = cyc + 1;
    done_at = d;
    while (cyc < d + 2) tick();
    checks++; if (bus.count !== 5'd3 || bus.busy !== 1'b1) begin failures++; $display("FAIL simul_count_at_load count=%0d busy=%b exp count=3 busy=1", bus.count, bus.busy); end
    hold_done = 1'b0;
    done_delay = $urandom_range(30, 4);
    push(8'h77);
    checks++; if (bus.count !== 5'd3) begin failures++; $display("FAIL simul_count_after got=%0d exp=3", bus.count); end
    wait_idle(1000);
    checks++; if (start_cyc.size() != 5) begin failures++; $display("FAIL simul_start_count got=%0d exp=5", start_cyc.size()); end
    for (int i = 0; i < start_cyc.size() && i < 5; i++) begin
      checks++; if (start_dat[i] !== a[i]) begin failures++; $display("FAIL simul_data[%0d] got=%h exp=%h", i, start_dat[i], a[i]); end
    end
    checks++; if (start_cyc.size() < 2 || start_cyc[1] != d + 3) begin failures++; $display("FAIL simul_restart starts=%0d exp second start at done+3", start_cyc.size()); end
  endtask
  task automatic test_timeout();
    logic [7:0] x, y;
    int s;
    int n;
    clear_logs();
    x = 8'($urandom);
    y = 8'($urandom);
    hold_done = 1'b1;
    push(x);
    push(y);
    for (n = 0; n < 10 && start_cyc.size() == 0; n++) tick();
    s = start_cyc.size() > 0 ? start_cyc[0] : cyc;
    for (n = 0; n < TMO + 20 && bus.tx_err !== 1'b1; n++) tick();
    checks++; if (cyc != s + TMO + 1) begin failures++; $display("FAIL timeout_tx_err_cycle got=%0d exp=%0d", cyc - s, TMO + 1); end
    for (n = 0; n < 10 && start_cyc.size() < 2; n++) tick();
    checks++; if (start_cyc.size() != 2) begin failures++; $display("FAIL timeout_next_start starts=%0d exp=2", start_cyc.size()); end
    else begin
      checks++; if (start_cyc[1] != s + TMO + 3) begin failures++; $display("FAIL timeout_next_latency got=%0d exp=%0d", start_cyc[1] - s, TMO + 3); end
      checks++; if (start_dat[1] !== y || start_dat[0] !== x) begin failures++; $display("FAIL timeout_data got=%h,%h exp=%h,%h", start_dat[0], start_dat[1], x, y); end
    end
    hold_done = 1'b0;
    done_at = cyc + 2;
    wait_idle(600);
    checks++; if (bus.tx_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", bus.tx_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.tx_err !== 1'b0 || bus.overflow !== 1'b0) begin failures++; $display("FAIL timeout_rst_clear tx_err=%b overflow=%b exp 0 0", bus.tx_err, bus.overflow); end
  endtask
  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] v;
    clear_logs();
    hold_done = 1'b0;
    for (int r = 0; r < 5; r++) begin
      done_delay = $urandom_range(60, 3);
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
        v = 8'($urandom);
        q.push_back(v);
        push(v);
        repeat ($urandom_range(2, 0)) tick();
      end
      wait_idle(3000);
    end
    checks++; if (start_cyc.size() != q.size()) begin failures++; $display("FAIL random_start_count got=%0d exp=%0d", start_cyc.size(), q.size()); end
    for (int i = 0; i < start_cyc.size() && i < q.size(); i++) begin
      checks++; if (start_dat[i] !== q[i]) begin failures++; $display("FAIL random_data[%0d] got=%h exp=%h", i, start_dat[i], q[i]); end
    end
    checks++; if (stab_bad != 0 || bus.overflow !== 1'b0 || bus.tx_err !== 1'b0) begin
      failures++; $display("FAIL random_flags changes=%0d overflow=%b tx_err=%b exp 0 0 0", stab_bad, bus.overflow, bus.tx_err);
    end
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_done = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_simul_push_pop();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
